// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control FSM with memory handshake, HALT/resume and retire counter.
// Optional: define CTRL_MEM_TIMEOUT_EN to halt with a sticky err after MEM_TIMEOUT stalled cycles.
module control_sequencer #(
    parameter int INSTR_W     = 8,
    parameter int OFF_W       = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zf,
    input  logic               mem_ready,
    input  logic               resume,
    output logic [2:0]         state,
    output logic               pc_we,
    output logic               pc_sel,
    output logic [OFF_W-1:0]   pc_offset,
    output logic               addr_sel,
    output logic [OFF_W-1:0]   addr_offset,
    output logic               mem_req,
    output logic               mem_sel,
    output logic               mem_we,
    output logic [2:0]         alu_opcode,
    output logic               alu_sel_a,
    output logic               alu_sel_b,
    output logic               alu_we,
    output logic               zf_we,
    output logic               ir_we,
    output logic               a_sel,
    output logic               a_we,
    output logic               b_sel,
    output logic               b_we,
    output logic               halt,
    output logic               err,
    output logic [CNT_W-1:0]   instr_count
);

    typedef enum logic [2:0] {
        FETCH     = 3'b000,
        DECODE    = 3'b001,
        EXECUTE   = 3'b010,
        MEMORY    = 3'b011,
        WRITEBACK = 3'b100,
        HALT      = 3'b101
    } state_e;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_LDB = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         opcode;
    logic [OFF_W-1:0]   operand;
    logic               retire;
    logic               stall;
    logic               tmo_hit;
    logic               err_set;
    logic               lint_unused;

    assign opcode  = instr[INSTR_W-1 -: 3];
    assign operand = instr[OFF_W-1:0];
    assign stall   = (state_q == FETCH || state_q == MEMORY) && !mem_ready;

    assign state       = reset ? 3'b000 : 3'(state_q);
    assign instr_count = reset ? '0 : count_q;

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        err_set     = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        pc_offset   = '0;
        addr_sel    = 1'b0;
        addr_offset = '0;
        mem_req     = 1'b0;
        mem_sel     = 1'b0;
        mem_we      = 1'b0;
        alu_opcode  = 3'b000;
        alu_sel_a   = 1'b0;
        alu_sel_b   = 1'b0;
        alu_we      = 1'b0;
        zf_we       = 1'b0;
        ir_we       = 1'b0;
        a_sel       = 1'b0;
        a_we        = 1'b0;
        b_sel       = 1'b0;
        b_we        = 1'b0;
        halt        = 1'b0;
        if (!reset) begin
            unique case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = DECODE;
                    end else if (tmo_hit) begin
                        state_d = HALT;
                        err_set = 1'b1;
                    end
                end
                DECODE: state_d = EXECUTE;
                EXECUTE: begin
                    case (opcode)
                        OP_LDA, OP_LDB, OP_STA: state_d = MEMORY;
                        OP_ADD, OP_SUB: begin
                            alu_opcode = (opcode == OP_SUB) ? 3'b001 : 3'b000;
                            alu_we     = 1'b1;
                            zf_we      = 1'b1;
                            state_d    = WRITEBACK;
                        end
                        OP_JZ, OP_JMP: begin
                            // JZ only redirects when the zero flag is set
                            if (opcode == OP_JMP || zf) begin
                                pc_we     = 1'b1;
                                pc_sel    = 1'b1;
                                pc_offset = operand;
                            end
                            state_d = FETCH;
                            retire  = 1'b1;
                        end
                        default: begin
                            state_d = HALT;
                            retire  = 1'b1;
                        end
                    endcase
                end
                MEMORY: begin
                    mem_req     = 1'b1;
                    addr_sel    = 1'b1;
                    addr_offset = operand;
                    case (opcode)
                        OP_LDA: begin
                            a_sel = 1'b1;
                            a_we  = mem_ready;
                        end
                        OP_LDB: begin
                            b_sel = 1'b1;
                            b_we  = mem_ready;
                        end
                        OP_STA: begin
                            mem_sel = 1'b1;
                            mem_we  = 1'b1;
                        end
                        default: ;
                    endcase
                    if (mem_ready) begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end else if (tmo_hit) begin
                        state_d = HALT;
                        err_set = 1'b1;
                    end
                end
                WRITEBACK: begin
                    a_we    = 1'b1;
                    state_d = FETCH;
                    retire  = 1'b1;
                end
                HALT: begin
                    halt = 1'b1;
                    if (resume) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_comb begin
        count_d = count_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    assign tmo_hit     = stall && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));
    assign err         = err_q & ~reset;
    assign lint_unused = ^{instr, MEM_TIMEOUT};

    always_comb begin
        tmo_d = '0;
        if (stall && state_d == state_q) tmo_d = tmo_q + TMO_W'(1);
    end

    always_comb begin
        err_d = err_q;
        if (state_q == HALT && resume) err_d = 1'b0;
        if (err_set) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign err         = 1'b0;
    assign lint_unused = ^{instr, MEM_TIMEOUT, err_set, stall};
`endif

endmodule
